// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and constants for the register-bus arbiter.
// Bus widths come from the global macros REG_ADDR_SZ / REG_DATA_SZ.
`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 16
`endif

package reg_arb_pkg;

    // Arbiter sequencing: accept, one bus access, one response pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Response data returned for writes
    localparam logic [`REG_DATA_SZ-1:0] RSP_ZERO = '0;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational circular first-one search.
// Scans the request vector starting at index 'start' and wrapping at
// NUM_REQ; returns the one-hot grant and the binary index of the winner.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Search from start, first active request after wrap-around wins
    always_comb begin
        int  cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(start) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register bus between NUM_REQ masters.
// Each accepted request produces exactly one bus strobe one cycle after
// acceptance and a one-cycle response pulse the cycle after that.
// Optional feature: define REG_ARB_RR_EN for round-robin arbitration;
// without it the lowest-index requester always wins.
`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 16
`endif

module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0]                       req_wr,
    input  logic [NUM_REQ-1:0][`REG_ADDR_SZ-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][`REG_DATA_SZ-1:0]     req_wr_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic [`REG_DATA_SZ-1:0]                  rsp_rd_data,
    output logic                                     reg_rd_en,
    output logic                                     reg_wr_en,
    output logic [`REG_ADDR_SZ-1:0]                  reg_addr,
    output logic [`REG_DATA_SZ-1:0]                  reg_wr_data,
    input  logic [`REG_DATA_SZ-1:0]                  reg_rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_req;

    assign any_req = |req_valid;

`ifdef REG_ARB_RR_EN
    logic [IDX_W-1:0] last_grant;

    // Search begins just past the most recent winner
    assign start_idx = (last_grant == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : last_grant + IDX_W'(1);
`else
    assign start_idx = '0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req_valid),
        .start     (start_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accept is combinational and only possible while idle
    assign req_ready = (state == IDLE) ? grant : '0;

    // Sequencer: accept -> one bus strobe -> one response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_idx     <= '0;
            rsp_valid   <= '0;
            rsp_rd_data <= '0;
            reg_rd_en   <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
`ifdef REG_ARB_RR_EN
            last_grant  <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_idx     <= grant_idx;
                        reg_addr    <= req_addr[grant_idx];
                        reg_wr_data <= req_wr_data[grant_idx];
                        reg_wr_en   <= req_wr[grant_idx];
                        reg_rd_en   <= ~req_wr[grant_idx];
`ifdef REG_ARB_RR_EN
                        last_grant  <= grant_idx;
`endif
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    reg_rd_en   <= 1'b0;
                    reg_wr_en   <= 1'b0;
                    rsp_rd_data <= reg_rd_en ? reg_rd_data : RSP_ZERO;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        rsp_valid[i] <= (win_idx == IDX_W'(i));
                    end
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed-vector bench for reg_bus_arbiter, NUM_REQ=2.
// Expectations follow the build: REG_ARB_RR_EN selects round-robin results.
`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 16
`endif

module tb_reg_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = `REG_ADDR_SZ;
    localparam int DW = `REG_DATA_SZ;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_wr;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][DW-1:0]   req_wr_data;
    logic [N-1:0]           req_ready;
    logic [N-1:0]           rsp_valid;
    logic [DW-1:0]          rsp_rd_data;
    logic                   reg_rd_en;
    logic                   reg_wr_en;
    logic [AW-1:0]          reg_addr;
    logic [DW-1:0]          reg_wr_data;
    logic [DW-1:0]          reg_rd_data;

    int total;
    int bad;

    reg_bus_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .reg_rd_en   (reg_rd_en),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [N-1:0] exp_g;
    logic [N-1:0] rr_exp;

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_wr      = '0;
        req_addr    = '0;
        req_wr_data = '0;
        reg_rd_data = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_req_ready",   32'(req_ready),   32'h0);
        check_eq("rst_rsp_valid",   32'(rsp_valid),   32'h0);
        check_eq("rst_rsp_rd_data", 32'(rsp_rd_data), 32'h0);
        check_eq("rst_rd_en",       32'(reg_rd_en),   32'h0);
        check_eq("rst_wr_en",       32'(reg_wr_en),   32'h0);
        check_eq("rst_reg_addr",    32'(reg_addr),    32'h0);
        check_eq("rst_reg_wr_data", 32'(reg_wr_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single read: requester 0, addr 0x4, bus returns 0xA5
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b0;
        req_addr[0]  = AW'(8'h04);
        #1;
        check_eq("rd_accept", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        reg_rd_data  = DW'(16'h00A5);
        check_eq("rd_strobe",   32'(reg_rd_en), 32'h1);
        check_eq("rd_no_wr",    32'(reg_wr_en), 32'h0);
        check_eq("rd_addr",     32'(reg_addr),  32'h4);
        check_eq("rd_no_ready", 32'(req_ready), 32'h0);
        tick();
        reg_rd_data = '0;
        check_eq("rd_rsp_valid", 32'(rsp_valid),   32'h1);
        check_eq("rd_rsp_data",  32'(rsp_rd_data), 32'hA5);
        check_eq("rd_strobe_off", 32'(reg_rd_en),  32'h0);
        tick();
        check_eq("rd_rsp_drop", 32'(rsp_valid), 32'h0);

        // Single write: requester 1 writes 0x3C to addr 0x2; bus data is junk
        req_valid[1]   = 1'b1;
        req_wr[1]      = 1'b1;
        req_addr[1]    = AW'(8'h02);
        req_wr_data[1] = DW'(16'h003C);
        #1;
        check_eq("wr_accept", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        reg_rd_data  = DW'(16'hFFFF);
        check_eq("wr_strobe",  32'(reg_wr_en),   32'h1);
        check_eq("wr_no_rd",   32'(reg_rd_en),   32'h0);
        check_eq("wr_addr",    32'(reg_addr),    32'h2);
        check_eq("wr_data",    32'(reg_wr_data), 32'h3C);
        tick();
        check_eq("wr_rsp_valid", 32'(rsp_valid),   32'h2);
        check_eq("wr_rsp_zero",  32'(rsp_rd_data), 32'h0);
        check_eq("wr_strobe_off", 32'(reg_wr_en),  32'h0);
        check_eq("wr_addr_hold", 32'(reg_addr),    32'h2);
        tick();
        reg_rd_data = '0;

        // Contention from a fresh reset: both request continuously
        do_reset();
        req_wr      = '0;
        req_addr[0] = AW'(8'h10);
        req_addr[1] = AW'(8'h11);
        req_valid   = 2'b11;
        rr_exp      = 2'b01;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k % 3 == 0) begin
`ifdef REG_ARB_RR_EN
                exp_g  = rr_exp;
                rr_exp = ~rr_exp;
`else
                exp_g = 2'b01;
`endif
            end else begin
                exp_g = 2'b00;
            end
            check_eq($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'(exp_g));
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();

        // Withdrawal: requester 1 raises during ACCESS, drops before IDLE
        req_valid[0] = 1'b1;
        req_addr[0]  = AW'(8'h07);
        #1;
        check_eq("wd_accept0", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        check_eq("wd_access_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("wd_resp_ready", 32'(req_ready), 32'h0);
        check_eq("wd_rsp0",       32'(rsp_valid), 32'h1);
        req_valid[1] = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("wd_no_strobe_%0d", k), 32'({reg_rd_en, reg_wr_en}), 32'h0);
            check_eq($sformatf("wd_no_rsp_%0d", k),    32'(rsp_valid), 32'h0);
            tick();
        end

        // Reset mid-access: strobe drops at once, no response follows
        req_valid[1] = 1'b1;
        req_wr[1]    = 1'b0;
        req_addr[1]  = AW'(8'h09);
        #1;
        check_eq("mr_accept1", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        check_eq("mr_strobe", 32'(reg_rd_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_strobe_drop", 32'(reg_rd_en), 32'h0);
        check_eq("mr_addr_clear",  32'(reg_addr),  32'h0);
        tick();
        check_eq("mr_no_rsp", 32'(rsp_valid), 32'h0);
        #2;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        check_eq("mr_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_eq("mr_no_rsp_late", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("mr_rsp_new", 32'(rsp_valid), 32'h1);
        tick();

        // Back-to-back reads from requester 0, addresses 0..3
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b0;
        req_addr[0]  = AW'(0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("b2b_accept_%0d", i), 32'(req_ready), 32'h1);
            check_eq($sformatf("b2b_idle_nostrobe_%0d", i), 32'(reg_rd_en), 32'h0);
            tick();
            reg_rd_data = DW'(16'h0100 + i);
            check_eq($sformatf("b2b_strobe_%0d", i), 32'(reg_rd_en), 32'h1);
            check_eq($sformatf("b2b_addr_%0d", i),   32'(reg_addr),  32'(i));
            if (i == 3) begin
                req_valid[0] = 1'b0;
            end else begin
                req_addr[0] = AW'(i + 1);
            end
            tick();
            check_eq($sformatf("b2b_rsp_%0d", i),  32'(rsp_valid),   32'h1);
            check_eq($sformatf("b2b_data_%0d", i), 32'(rsp_rd_data), 32'h100 + 32'(i));
            check_eq($sformatf("b2b_resp_nostrobe_%0d", i), 32'(reg_rd_en), 32'h0);
            tick();
        end
        reg_rd_data = '0;
        #1;
        check_eq("b2b_done_ready", 32'(req_ready), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
